// File: rtl/add_mul_flow_pkg.sv
// Shared widths, payload types and width helpers for the add_mul_flow pipeline.
package add_mul_flow_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  // P0 payload: raw operands as sampled on input transfer.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] x;
    logic [WIDTH_DEFAULT-1:0] y;
    logic [WIDTH_DEFAULT-1:0] z;
  } p0_pld_t;

  // P1 payload: wrapped sum plus the multiplier carried alongside.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] sum;
    logic [WIDTH_DEFAULT-1:0] z;
  } p1_pld_t;

  // Flat payload widths for an arbitrary operand width.
  function automatic int unsigned p0_width(input int unsigned w);
    return 3 * w;
  endfunction

  function automatic int unsigned p1_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/add_mul_flow_cycle0.sv
// Stage 0: wrapping add of the operands, multiplier passed through.
module add_mul_flow_cycle0 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] z_o
);

  // Carry out of the add is intentionally dropped.
  always_comb begin
    sum_o = x_i + y_i;
    z_o   = z_i;
  end

endmodule

// File: rtl/add_mul_flow_cycle1.sv
// Stage 1: unsigned multiply keeping the low WIDTH bits of the product.
module add_mul_flow_cycle1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] z_i,
  output logic [WIDTH-1:0] prod_o
);

  // Self-determined WIDTH-bit multiply truncates the upper half.
  always_comb begin
    prod_o = sum_i * z_i;
  end

endmodule

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus payload, loads when its advance term is set.
module pipe_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         adv_i,
  input  logic         up_vld_i,
  input  logic [W-1:0] up_data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic         vld_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Valid follows the advance rule; data only moves when a real item arrives.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv_i) begin
      vld_d = up_vld_i;
      if (up_vld_i) begin
        data_d = up_data_i;
      end
    end
  end

  // Slot registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/add_mul_flow.sv
// Flow-controlled (x + y) * z pipeline with valid/ready on both ends.
module add_mul_flow
  import add_mul_flow_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned P0_W = p0_width(WIDTH);
  localparam int unsigned P1_W = p1_width(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } p0_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] z;
  } p1_t;

  logic             adv0_c;
  logic             adv1_c;
  logic             adv2_c;

  logic             p0_vld;
  logic             p1_vld;
  logic             p2_vld;

  p0_t              p0_in_c;
  p0_t              p0_data;
  p1_t              p1_in_c;
  p1_t              p1_data;
  logic [WIDTH-1:0] p2_in_c;
  logic [WIDTH-1:0] p2_data;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] z1_c;

  // Ready chain: a slot advances if it is empty or the slot below advances.
  always_comb begin
    adv2_c = !p2_vld || out_rdy;
    adv1_c = !p1_vld || adv2_c;
    adv0_c = !p0_vld || adv1_c;
    in_rdy = adv0_c && rst;
  end

  // Pack incoming operands and stage-0 results into slot payloads.
  always_comb begin
    p0_in_c.x   = x;
    p0_in_c.y   = y;
    p0_in_c.z   = z;
    p1_in_c.sum = sum_c;
    p1_in_c.z   = z1_c;
  end

  pipe_slot #(.W(P0_W)) u_p0 (
    .clk       (clk),
    .rst_n_i   (rst),
    .adv_i     (adv0_c),
    .up_vld_i  (in_vld),
    .up_data_i (p0_in_c),
    .vld_o     (p0_vld),
    .data_o    (p0_data)
  );

  add_mul_flow_cycle0 #(.WIDTH(WIDTH)) u_cycle0 (
    .x_i   (p0_data.x),
    .y_i   (p0_data.y),
    .z_i   (p0_data.z),
    .sum_o (sum_c),
    .z_o   (z1_c)
  );

  pipe_slot #(.W(P1_W)) u_p1 (
    .clk       (clk),
    .rst_n_i   (rst),
    .adv_i     (adv1_c),
    .up_vld_i  (p0_vld),
    .up_data_i (p1_in_c),
    .vld_o     (p1_vld),
    .data_o    (p1_data)
  );

  add_mul_flow_cycle1 #(.WIDTH(WIDTH)) u_cycle1 (
    .sum_i  (p1_data.sum),
    .z_i    (p1_data.z),
    .prod_o (p2_in_c)
  );

  pipe_slot #(.W(WIDTH)) u_p2 (
    .clk       (clk),
    .rst_n_i   (rst),
    .adv_i     (adv2_c),
    .up_vld_i  (p1_vld),
    .up_data_i (p2_in_c),
    .vld_o     (p2_vld),
    .data_o    (p2_data)
  );

  // Output comes straight from the last slot, independent of out_rdy.
  always_comb begin
    out_vld = p2_vld;
    out     = p2_data;
  end

endmodule

// File: tb/tb_add_mul_flow.sv
// Scoreboard bench for add_mul_flow: directed scenarios plus random valid/ready.
module tb_add_mul_flow;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] x, y, z;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sb[$];
  logic [31:0] exp_v;

  bit          s_acc, s_xfer, s_in_rdy, s_out_vld;
  logic [31:0] s_out;

  always #5 clk = ~clk;

  add_mul_flow #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .x       (x),
    .y       (y),
    .z       (z),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out     (out)
  );

  // Sample at the falling edge, then let the rising edge happen.
  task automatic step();
    @(negedge clk);
    s_in_rdy  = in_rdy;
    s_out_vld = out_vld;
    s_out     = out;
    s_acc     = in_vld && in_rdy;
    s_xfer    = out_vld && out_rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    logic [31:0] s;
    s = a + b;
    return s * c;
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_vld = 1'b1; out_rdy = 1'b1;
    x = 32'd1; y = 32'd2; z = 32'd3;
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++;
      if (s_in_rdy !== 1'b0) begin
        n_err++; $display("FAIL reset_in_rdy: got %0b want 0", s_in_rdy);
      end
    end
    n_vec++;
    if (out_vld !== 1'b0 || out !== 32'd0) begin
      n_err++; $display("FAIL reset_out: got vld=%0b out=%h want vld=0 out=0", out_vld, out);
    end
    rst = 1'b1; in_vld = 1'b0;
    step();
    n_vec++;
    if (s_in_rdy !== 1'b1) begin
      n_err++; $display("FAIL reset_release_in_rdy: got %0b want 1", s_in_rdy);
    end
  endtask

  task automatic test_single();
    in_vld = 1'b1; x = 32'd3; y = 32'd4; z = 32'd5; out_rdy = 1'b1;
    step();
    n_vec++;
    if (s_acc !== 1'b1) begin
      n_err++; $display("FAIL single_accept: got %0b want 1", s_acc);
    end
    in_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_vec++;
      if (s_out_vld !== (k == 3)) begin
        n_err++; $display("FAIL single_latency cyc%0d: got vld=%0b want %0b", k, s_out_vld, (k == 3));
      end
      if (k == 3) begin
        n_vec++;
        if (s_out !== 32'd35) begin
          n_err++; $display("FAIL single_value: got %0d want 35", s_out);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] vx[3], vy[3], vz[3], ve[3];
    int pops;
    vx[0] = 32'hFFFF_FFFF; vy[0] = 32'd1; vz[0] = 32'd7;          ve[0] = 32'd0;
    vx[1] = 32'h0001_0000; vy[1] = 32'd0; vz[1] = 32'h0001_0000;  ve[1] = 32'd0;
    vx[2] = 32'hFFFF_FFFF; vy[2] = 32'd0; vz[2] = 32'd2;          ve[2] = 32'hFFFF_FFFE;
    pops = 0;
    out_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        in_vld = 1'b1; x = vx[c]; y = vy[c]; z = vz[c];
      end else begin
        in_vld = 1'b0;
      end
      step();
      if (s_acc) sb.push_back(ve[c]);
      if (s_xfer) begin
        pops++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL wrap_extra: got %h want none", s_out);
        end else begin
          exp_v = sb.pop_front();
          if (s_out !== exp_v) begin
            n_err++; $display("FAIL wrap_value: got %h want %h", s_out, exp_v);
          end
        end
      end
    end
    n_vec++;
    if (pops !== 3) begin
      n_err++; $display("FAIL wrap_count: got %0d want 3", pops);
    end
  endtask

  task automatic test_back_to_back();
    int pops;
    pops = 0;
    out_rdy = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        in_vld = 1'b1; x = 32'(c); y = 32'(c); z = 32'd1;
      end else begin
        in_vld = 1'b0;
      end
      step();
      if (c < 8) begin
        n_vec++;
        if (s_in_rdy !== 1'b1) begin
          n_err++; $display("FAIL stream_in_rdy cyc%0d: got %0b want 1", c, s_in_rdy);
        end
        if (s_acc) sb.push_back(32'(2 * c));
      end
      n_vec++;
      if (s_out_vld !== (c >= 3 && c <= 10)) begin
        n_err++; $display("FAIL stream_timing cyc%0d: got vld=%0b want %0b", c, s_out_vld, (c >= 3 && c <= 10));
      end
      if (s_xfer) begin
        pops++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL stream_extra: got %0d want none", s_out);
        end else begin
          exp_v = sb.pop_front();
          if (s_out !== exp_v) begin
            n_err++; $display("FAIL stream_value: got %0d want %0d", s_out, exp_v);
          end
        end
      end
    end
    n_vec++;
    if (pops !== 8) begin
      n_err++; $display("FAIL stream_count: got %0d want 8", pops);
    end
  endtask

  task automatic test_backpressure();
    int idx, pops;
    logic [31:0] held;
    idx = 0; pops = 0;
    out_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_vld = 1'b1; x = 32'(10 + idx); y = 32'(idx); z = 32'd3;
      step();
      if (s_acc) begin
        sb.push_back(model(x, y, z));
        idx++;
      end
      if (c == 3) held = s_out;
      if (c > 3) begin
        n_vec++;
        if (s_out_vld !== 1'b1 || s_out !== held) begin
          n_err++; $display("FAIL bp_stable: got vld=%0b out=%0d want vld=1 out=%0d", s_out_vld, s_out, held);
        end
      end
    end
    n_vec++;
    if (idx !== 3) begin
      n_err++; $display("FAIL bp_capacity: got %0d accepted want 3", idx);
    end
    n_vec++;
    if (s_in_rdy !== 1'b0) begin
      n_err++; $display("FAIL bp_in_rdy_low: got %0b want 0", s_in_rdy);
    end
    for (int c = 0; c < 15; c++) begin
      out_rdy = 1'b1;
      in_vld = (idx < 5);
      x = 32'(10 + idx); y = 32'(idx); z = 32'd3;
      step();
      if (c == 0) begin
        n_vec++;
        if (!(s_acc && s_xfer)) begin
          n_err++; $display("FAIL bp_same_edge: got acc=%0b xfer=%0b want 1 1", s_acc, s_xfer);
        end
      end
      if (s_acc) begin
        sb.push_back(model(x, y, z));
        idx++;
      end
      if (s_xfer) begin
        pops++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL bp_extra: got %0d want none", s_out);
        end else begin
          exp_v = sb.pop_front();
          if (s_out !== exp_v) begin
            n_err++; $display("FAIL bp_value: got %0d want %0d", s_out, exp_v);
          end
        end
      end
    end
    in_vld = 1'b0;
    n_vec++;
    if (pops !== 5 || sb.size() != 0) begin
      n_err++; $display("FAIL bp_drain: got %0d outputs left=%0d want 5 left=0", pops, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_vld = 1'b1; x = 32'(c + 1); y = 32'd1; z = 32'd9;
      step();
      if (s_acc) sb.push_back(model(x, y, z));
    end
    in_vld = 1'b0;
    n_vec++;
    if (sb.size() != 3) begin
      n_err++; $display("FAIL mid_fill: got %0d in flight want 3", sb.size());
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (s_in_rdy !== 1'b0) begin
      n_err++; $display("FAIL mid_in_rdy: got %0b want 0", s_in_rdy);
    end
    n_vec++;
    if (out_vld !== 1'b0 || out !== 32'd0) begin
      n_err++; $display("FAIL mid_cleared: got vld=%0b out=%h want 0 0", out_vld, out);
    end
    rst = 1'b1;
    sb.delete();
    out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      n_vec++;
      if (s_out_vld !== 1'b0) begin
        n_err++; $display("FAIL mid_stale cyc%0d: got vld=%0b out=%h want vld=0", c, s_out_vld, s_out);
      end
    end
  endtask

  task automatic test_random();
    bit          prev_stall;
    logic [31:0] prev_out;
    prev_stall = 1'b0; prev_out = '0;
    in_vld = 1'b0;
    s_acc = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!in_vld || s_acc) begin
        in_vld = ($urandom_range(0, 3) != 0);
        x = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        y = $urandom;
        z = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      end
      out_rdy = ($urandom_range(0, 2) != 0);
      step();
      if (prev_stall) begin
        n_vec++;
        if (s_out_vld !== 1'b1 || s_out !== prev_out) begin
          n_err++; $display("FAIL rand_stable cyc%0d: got vld=%0b out=%h want vld=1 out=%h", c, s_out_vld, s_out, prev_out);
        end
      end
      if (s_acc) sb.push_back(model(x, y, z));
      if (s_xfer) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rand_extra cyc%0d: got %h want none", c, s_out);
        end else begin
          exp_v = sb.pop_front();
          if (s_out !== exp_v) begin
            n_err++; $display("FAIL rand_value cyc%0d: got %h want %h", c, s_out, exp_v);
          end
        end
      end
      prev_stall = s_out_vld && !out_rdy;
      prev_out   = s_out;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_xfer) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rand_drain_extra: got %h want none", s_out);
        end else begin
          exp_v = sb.pop_front();
          if (s_out !== exp_v) begin
            n_err++; $display("FAIL rand_drain_value: got %h want %h", s_out, exp_v);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL rand_lost: got %0d results missing want 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    x = '0; y = '0; z = '0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
